// File: rtl/lab4_branch_pht_update_sched.sv
// Arbitrates the bimodal PHT index port between fetch lookups and queued branch updates.
// Optional counters: define LAB4_BRANCH_PHT_SCHED_STATS_EN to add stat_stalls/stat_updates.
module lab4_branch_pht_update_sched #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_val,
    output logic        lookup_rdy,
    input  logic [31:0] lookup_pc,
    output logic        pred_val,
    output logic        pred_taken,
    input  logic        upd_val,
    output logic        upd_rdy,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pht_pc,
    output logic        pht_update_en,
    output logic        pht_update_val,
    input  logic        pht_prediction,
    output logic        idle
`ifdef LAB4_BRANCH_PHT_SCHED_STATS_EN
    ,
    output logic [31:0] stat_stalls,
    output logic [31:0] stat_updates
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fifo_pc    [DEPTH];
    logic          fifo_taken [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [SW-1:0] starve_cnt;
    logic          full, enq, issue;

    assign full    = (count == FULL_CNT);
    assign upd_rdy = !full;
    assign enq     = upd_val && !full;
    // Reset gates issue so a mid-operation reset never writes the PHT.
    assign issue   = !reset && (count != '0) &&
                     (state == DRAIN || !lookup_val || starve_cnt == STARVE_LIM);

    always_comb begin
        count_nxt = count;
        case ({enq, issue})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enq) state_nxt = PEND;
            PEND: begin
                if (count_nxt == '0)           state_nxt = IDLE;
                else if (count_nxt == FULL_CNT) state_nxt = DRAIN;
            end
            DRAIN:   if (count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (enq)   wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            if (issue || count == '0)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Queue storage holds no control state, so it is left unreset.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_pc[wr_ptr]    <= upd_pc;
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

    always_comb begin
        pht_pc         = lookup_pc;
        pht_update_en  = 1'b0;
        pht_update_val = 1'b0;
        lookup_rdy     = 1'b1;
        if (issue) begin
            pht_pc         = fifo_pc[rd_ptr];
            pht_update_en  = 1'b1;
            pht_update_val = fifo_taken[rd_ptr];
            lookup_rdy     = 1'b0;
        end
    end

    assign pred_val   = lookup_val && lookup_rdy;
    assign pred_taken = pht_prediction;
    assign idle       = (count == '0) && (state == IDLE);

`ifdef LAB4_BRANCH_PHT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stalls  <= '0;
            stat_updates <= '0;
        end else begin
            if (lookup_val && !lookup_rdy) stat_stalls  <= stat_stalls + 32'd1;
            if (issue)                     stat_updates <= stat_updates + 32'd1;
        end
    end
`endif

endmodule
